approx_mult_pipe: RTL and testbench

Pipelined, parametrised unsigned W×W multiplier with per-transaction selection between exact and approximate reduction. The approximate path applies the probability-based approximate 4:2 compressor to the low APPROX_COLS columns of the partial-product matrix; all higher columns and all final summation are exact. It supersedes the fixed 8×8 combinational multipliers as the datapath multiplier in streaming filter and accelerator blocks. A valid/ready handshake on both sides supports back-pressure.

---
 rtl/approx_mult_pkg.sv | 36 +++
 rtl/approx_compressor_42.sv | 24 ++
 rtl/approx_mult_pipe.sv | 158 +++++++++++++++
 tb/tb_approx_mult_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared constants and partial-product geometry helpers for
// approx_mult_pipe.
//   MODE_EXACT / MODE_APPROX : encoding of the per-beat mode bit.
//   col_height()             : number of partial-product bits in a column.
//   col_lo()                 : lowest row index that has a bit in a column.
//   in_approx_group()        : whether bit (row i, column c) is consumed by a
//                              4:2 compressor group in approximate mode.
package approx_mult_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   function automatic int unsigned col_height(input int unsigned w, input int unsigned c);
      if (c >= 2 * w - 1) begin
         return 0;
      end
      if (c < w) begin
         return c + 1;
      end
      return 2 * w - 1 - c;
   endfunction

   function automatic int unsigned col_lo(input int unsigned w, input int unsigned c);
      return (c >= w) ? c - w + 1 : 0;
   endfunction

   // Bits are grouped in ascending row order; only complete groups of four
   // are compressed, the leftover tail of the column passes through.
   function automatic logic in_approx_group(input int unsigned w, input int unsigned ac,
                                            input int unsigned i, input int unsigned c);
      int unsigned h;
      h = col_height(w, c);
      return (c < ac) && ((i - col_lo(w, c)) < 4 * (h / 4));
   endfunction

endpackage

// File: rtl/approx_compressor_42.sv
// approx_compressor_42: probability-based approximate 4:2 compressor.
//   i_a..i_d : four bits of one partial-product column (weight 1).
//   o_sum    : result bit in the same column (weight 1).
//   o_carry  : result bit for the next column (weight 2).
// Any two set inputs produce a carry; a single set input produces a sum.
// The result therefore never exceeds the exact count of ones.
module approx_compressor_42
   import approx_mult_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   input  logic i_d,
   output logic o_sum,
   output logic o_carry
);

   logic w_carry;

   assign w_carry = (i_a & i_b) | (i_c & i_d) | ((i_a | i_b) & (i_c | i_d));
   assign o_carry = w_carry;
   assign o_sum   = (i_a | i_b | i_c | i_d) & ~w_carry;

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: three-stage pipelined unsigned W x W multiplier with a
// per-beat choice between exact and approximate partial-product reduction.
//   clk, rst              : clock (rising edge), asynchronous active-high reset.
//   in_valid/in_ready     : operand handshake; in_a, in_b operands, in_approx mode.
//   out_valid/out_ready   : product handshake; out_p product, out_approx mode tag.
//   busy                  : some pipeline stage holds a valid beat.
// S1 registers operands, S2 registers a carry-save pair, S3 the final product.
// The whole pipe stalls together when S3 holds a beat that is not taken.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int unsigned W           = 8,
   parameter int unsigned APPROX_COLS = W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic             out_approx,
   output logic             busy
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned NG = W / 4;          // max compressor groups per column
   localparam int unsigned NR = W + 2 * NG;     // pp rows + group sum rows + group carry rows

   // Pipeline state
   logic            r_rdy_en;
   logic            r_v1, r_v2, r_v3;
   logic [W-1:0]    r_a1, r_b1;
   logic            r_m1, r_m2, r_m3;
   logic [PW-1:0]   r_sum2, r_cry2;
   logic [PW-1:0]   r_p3;

   logic            w_adv;
   logic            w_acc;
   logic            w_apx;
   logic [NG-1:0]   w_cs [PW-1];
   logic [NG-1:0]   w_cc [PW-1];
   logic [PW-1:0]   w_rows [NR];
   logic [PW-1:0]   w_sum, w_cry;

   assign w_adv      = ~r_v3 | out_ready;
   // r_rdy_en holds in_ready low for the first cycle after reset release.
   assign in_ready   = r_rdy_en & w_adv;
   assign w_acc      = in_valid & in_ready;
   assign w_apx      = (r_m1 == MODE_APPROX);
   assign out_valid  = r_v3;
   assign out_p      = r_p3;
   assign out_approx = r_m3;
   assign busy       = r_v1 | r_v2 | r_v3;

   // Approximate compressors on the low columns. The top column (2W-1) is
   // always empty, so it gets no slot.
   for (genvar c = 0; c < PW - 1; c++) begin : g_col
      localparam int unsigned Lo  = col_lo(W, c);
      localparam int unsigned Ngc = (c < APPROX_COLS) ? col_height(W, c) / 4 : 0;
      for (genvar g = 0; g < NG; g++) begin : g_grp
         if (g < Ngc) begin : g_cmp
            localparam int unsigned R0 = Lo + 4 * g;
            approx_compressor_42 u_cmp (
               .i_a     (r_a1[c-R0]   & r_b1[R0]),
               .i_b     (r_a1[c-R0-1] & r_b1[R0+1]),
               .i_c     (r_a1[c-R0-2] & r_b1[R0+2]),
               .i_d     (r_a1[c-R0-3] & r_b1[R0+3]),
               .o_sum   (w_cs[c][g]),
               .o_carry (w_cc[c][g])
            );
         end else begin : g_none
            assign w_cs[c][g] = 1'b0;
            assign w_cc[c][g] = 1'b0;
         end
      end
   end

   // Bit matrix seen by the exact reduction: partial-product rows with the
   // compressed bits removed (approx mode), plus one row per group slot for
   // compressor sums and one for compressor carries.
   always_comb begin
      for (int r = 0; r < NR; r++) begin
         w_rows[r] = '0;
      end
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            w_rows[i][i+j] = r_a1[j] & r_b1[i] &
                             ~(w_apx & in_approx_group(W, APPROX_COLS, i, i + j));
         end
      end
      if (w_apx) begin
         for (int c = 0; c < PW - 1; c++) begin
            for (int g = 0; g < NG; g++) begin
               w_rows[W+g][c]      = w_cs[c][g];
               w_rows[W+NG+g][c+1] = w_cc[c][g];
            end
         end
      end
   end

   // Exact carry-save reduction of all rows down to a sum/carry pair.
   always_comb begin
      logic [PW-1:0] w_t;
      w_sum = w_rows[0];
      w_cry = w_rows[1];
      w_t   = '0;
      for (int r = 2; r < NR; r++) begin
         w_t   = w_sum ^ w_cry ^ w_rows[r];
         w_cry = ((w_sum & w_cry) | (w_sum & w_rows[r]) | (w_cry & w_rows[r])) << 1;
         w_sum = w_t;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en <= 1'b0;
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_v3     <= 1'b0;
         r_a1     <= '0;
         r_b1     <= '0;
         r_m1     <= MODE_EXACT;
         r_sum2   <= '0;
         r_cry2   <= '0;
         r_m2     <= MODE_EXACT;
         r_p3     <= '0;
         r_m3     <= MODE_EXACT;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_adv) begin
            r_v1 <= w_acc;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            // Data registers only load on valid beats so outputs stay put
            // across bubbles.
            if (w_acc) begin
               r_a1 <= in_a;
               r_b1 <= in_b;
               r_m1 <= in_approx;
            end
            if (r_v1) begin
               r_sum2 <= w_sum;
               r_cry2 <= w_cry;
               r_m2   <= r_m1;
            end
            if (r_v2) begin
               r_p3 <= r_sum2 + r_cry2;
               r_m3 <= r_m2;
            end
         end
      end
   end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: self-checking bench for approx_mult_pipe.
//   dut_a : W=8,  APPROX_COLS=8  (directed values, back-pressure, reset mid-flight)
//   dut_b : W=8,  APPROX_COLS=0  (random approx beats must equal a*b)
//   dut_c : W=16, APPROX_COLS=16 (random alternating modes vs reference model)
module tb_approx_mult_pipe;
   import approx_mult_pkg::*;

   typedef struct {
      longint unsigned p;
      bit              m;
      longint unsigned ex;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        da_in_valid, da_in_ready, da_in_approx, da_out_valid, da_out_ready;
   logic        da_out_approx, da_busy;
   logic [7:0]  da_in_a, da_in_b;
   logic [15:0] da_out_p;

   logic        db_in_valid, db_in_ready, db_in_approx, db_out_valid, db_out_ready;
   logic        db_out_approx, db_busy;
   logic [7:0]  db_in_a, db_in_b;
   logic [15:0] db_out_p;

   logic        dc_in_valid, dc_in_ready, dc_in_approx, dc_out_valid, dc_out_ready;
   logic        dc_out_approx, dc_busy;
   logic [15:0] dc_in_a, dc_in_b;
   logic [31:0] dc_out_p;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned na_out   = 0;
   int unsigned nb_out   = 0;
   int unsigned nc_out   = 0;
   exp_t        qa[$], qb[$], qc[$];
   exp_t        ea, eb, ec;
   bit          ha_valid, hc_valid;
   longint unsigned ha_p, hc_p;
   bit          ha_m, hc_m;

   approx_mult_pipe #(.W(8), .APPROX_COLS(8)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(da_in_valid), .in_ready(da_in_ready),
      .in_a(da_in_a), .in_b(da_in_b), .in_approx(da_in_approx),
      .out_valid(da_out_valid), .out_ready(da_out_ready), .out_p(da_out_p),
      .out_approx(da_out_approx), .busy(da_busy)
   );

   approx_mult_pipe #(.W(8), .APPROX_COLS(0)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(db_in_valid), .in_ready(db_in_ready),
      .in_a(db_in_a), .in_b(db_in_b), .in_approx(db_in_approx),
      .out_valid(db_out_valid), .out_ready(db_out_ready), .out_p(db_out_p),
      .out_approx(db_out_approx), .busy(db_busy)
   );

   approx_mult_pipe #(.W(16), .APPROX_COLS(16)) u_dut_c (
      .clk(clk), .rst(rst), .in_valid(dc_in_valid), .in_ready(dc_in_ready),
      .in_a(dc_in_a), .in_b(dc_in_b), .in_approx(dc_in_approx),
      .out_valid(dc_out_valid), .out_ready(dc_out_ready), .out_p(dc_out_p),
      .out_approx(dc_out_approx), .busy(dc_busy)
   );

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Column-by-column value of the reduced matrix. A group of four with k ones
   // contributes min(k,2): any two ones raise the carry (weight 2) and clear
   // the sum, a lone one keeps only the sum.
   function automatic longint unsigned ref_mul(input longint unsigned a, input longint unsigned b,
                                               input bit apx, input int w, input int ac);
      longint unsigned acc;
      int h, nfull, pos, grp, bv;
      acc = 0;
      for (int c = 0; c < 2 * w; c++) begin
         h = 0;
         for (int i = 0; i < w; i++) begin
            if (c - i >= 0 && c - i < w) h++;
         end
         nfull = (apx && c < ac) ? (h / 4) * 4 : 0;
         pos = 0;
         grp = 0;
         for (int i = 0; i < w; i++) begin
            if (c - i >= 0 && c - i < w) begin
               bv = int'((a >> (c - i)) & 1) & int'((b >> i) & 1);
               if (pos < nfull) begin
                  grp += bv;
                  if (pos % 4 == 3) begin
                     acc += longint'((grp >= 2) ? 2 : grp) << c;
                     grp = 0;
                  end
               end else begin
                  acc += longint'(bv) << c;
               end
               pos++;
            end
         end
      end
      return acc & ((64'd1 << (2 * w)) - 1);
   endfunction

   // Monitors: sample at the falling edge; a handshake seen here completes at
   // the following rising edge.
   always @(negedge clk) begin
      if (rst) begin
         ha_valid = 0;
      end else begin
         if (ha_valid && da_out_valid) begin
            chk("a_hold_p", da_out_p, ha_p);
            chk("a_hold_m", da_out_approx, ha_m);
         end
         ha_valid = da_out_valid && !da_out_ready;
         ha_p = da_out_p;
         ha_m = da_out_approx;
         if (da_in_valid && da_in_ready) begin
            ea.p  = ref_mul(da_in_a, da_in_b, da_in_approx, 8, 8);
            ea.m  = da_in_approx;
            ea.ex = longint'(da_in_a) * longint'(da_in_b);
            qa.push_back(ea);
         end
         if (da_out_valid && da_out_ready) begin
            if (qa.size() == 0) begin
               chk("a_spurious_out", da_out_valid, 0);
            end else begin
               ea = qa.pop_front();
               chk("a_p", da_out_p, ea.p);
               chk("a_m", da_out_approx, ea.m);
               na_out++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (db_in_valid && db_in_ready) begin
            eb.p  = longint'(db_in_a) * longint'(db_in_b);
            eb.m  = db_in_approx;
            eb.ex = eb.p;
            qb.push_back(eb);
         end
         if (db_out_valid && db_out_ready) begin
            if (qb.size() == 0) begin
               chk("b_spurious_out", db_out_valid, 0);
            end else begin
               eb = qb.pop_front();
               chk("b_p", db_out_p, eb.p);
               chk("b_m", db_out_approx, eb.m);
               nb_out++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hc_valid = 0;
      end else begin
         if (hc_valid && dc_out_valid) begin
            chk("c_hold_p", dc_out_p, hc_p);
            chk("c_hold_m", dc_out_approx, hc_m);
         end
         hc_valid = dc_out_valid && !dc_out_ready;
         hc_p = dc_out_p;
         hc_m = dc_out_approx;
         if (dc_in_valid && dc_in_ready) begin
            ec.p  = ref_mul(dc_in_a, dc_in_b, dc_in_approx, 16, 16);
            ec.m  = dc_in_approx;
            ec.ex = longint'(dc_in_a) * longint'(dc_in_b);
            qc.push_back(ec);
         end
         if (dc_out_valid && dc_out_ready) begin
            if (qc.size() == 0) begin
               chk("c_spurious_out", dc_out_valid, 0);
            end else begin
               ec = qc.pop_front();
               chk("c_p", dc_out_p, ec.p);
               chk("c_m", dc_out_approx, ec.m);
               chk("c_not_above_exact", longint'(dc_out_p) <= ec.ex, 1);
               nc_out++;
            end
         end
      end
   end

   // One beat into an idle dut_a; the product must be visible in the third
   // cycle after the accepting edge. Called at posedge+1.
   task automatic a_single(input logic [7:0] x, input logic [7:0] y, input logic m,
                           input longint unsigned ep);
      chk("single_in_ready", da_in_ready, 1);
      da_in_valid  = 1;
      da_in_a      = x;
      da_in_b      = y;
      da_in_approx = m;
      @(posedge clk); #1;
      da_in_valid = 0;
      chk("single_lat1", da_out_valid, 0);
      @(posedge clk); #1;
      chk("single_lat2", da_out_valid, 0);
      @(posedge clk); #1;
      chk("single_valid", da_out_valid, 1);
      chk("single_p", da_out_p, ep);
      chk("single_m", da_out_approx, m);
      @(posedge clk); #1;
      chk("single_idle", da_busy, 0);
   endtask

   task automatic a_backpressure();
      int nstall;
      int unsigned na_start;
      nstall   = 0;
      na_start = na_out;
      fork
         begin
            for (int n = 0; n < 10; n++) begin
               bit acc;
               int guard;
               acc   = 0;
               guard = 0;
               da_in_valid  = 1;
               da_in_a      = 8'($urandom);
               da_in_b      = 8'($urandom);
               da_in_approx = 1'($urandom);
               while (!acc && guard < 50) begin
                  @(negedge clk);
                  acc = da_in_valid && da_in_ready;
                  if (da_out_valid && !da_out_ready) begin
                     chk("bp_in_ready_low", da_in_ready, 0);
                     nstall++;
                  end
                  @(posedge clk); #1;
                  guard++;
               end
               chk("bp_accept", acc, 1);
            end
            da_in_valid = 0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 da_out_ready = 0;
            repeat (5) @(posedge clk);
            #1 da_out_ready = 1;
         end
      join
      for (int t = 0; t < 20 && qa.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("bp_drain", qa.size(), 0);
      chk("bp_count", na_out - na_start, 10);
      chk("bp_stall_seen", nstall > 0, 1);
   endtask

   initial begin
      int guard;
      int unsigned sent;
      bit mode;

      rst = 1;
      da_in_valid = 0; da_in_a = 0; da_in_b = 0; da_in_approx = 0; da_out_ready = 1;
      db_in_valid = 0; db_in_a = 0; db_in_b = 0; db_in_approx = 0; db_out_ready = 1;
      dc_in_valid = 0; dc_in_a = 0; dc_in_b = 0; dc_in_approx = 0; dc_out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", da_out_valid, 0);
      chk("rst_out_p", da_out_p, 0);
      chk("rst_out_approx", da_out_approx, 0);
      chk("rst_busy", da_busy, 0);
      chk("rst_in_ready", da_in_ready, 0);
      chk("rst_c_out_valid", dc_out_valid, 0);
      @(negedge clk);
      rst = 0;
      #1 chk("rdy_before_edge", da_in_ready, 0);
      @(posedge clk); #1;
      chk("rdy_after_edge", da_in_ready, 1);

      // Directed values
      a_single(8'd255, 8'd255, MODE_EXACT, 64'd65025);
      a_single(8'd255, 8'd255, MODE_APPROX, 64'd64273);
      a_single(8'd0, 8'd255, MODE_APPROX, 64'd0);

      a_backpressure();

      // Reset with three beats in flight
      da_out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         da_in_valid  = 1;
         da_in_a      = 8'($urandom);
         da_in_b      = 8'($urandom);
         da_in_approx = 1'(k);
         @(posedge clk); #1;
      end
      da_in_valid = 0;
      chk("mid_busy_before_rst", da_busy, 1);
      chk("mid_valid_before_rst", da_out_valid, 1);
      rst = 1;
      #1;
      chk("mid_rst_out_valid", da_out_valid, 0);
      chk("mid_rst_busy", da_busy, 0);
      chk("mid_rst_out_p", da_out_p, 0);
      chk("mid_rst_in_ready", da_in_ready, 0);
      qa.delete();
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      a_single(8'd3, 8'd5, MODE_EXACT, 64'd15);
      @(posedge clk); #1;
      chk("mid_no_leftover", da_out_valid, 0);

      // dut_b: APPROX_COLS=0, approx beats only
      sent = 0;
      guard = 0;
      while (sent < 1000 && guard < 5000) begin
         db_in_valid  = ($urandom % 4) != 0;
         db_in_a      = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
         db_in_b      = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
         db_in_approx = MODE_APPROX;
         @(negedge clk);
         if (db_in_valid && db_in_ready) sent++;
         @(posedge clk); #1;
         guard++;
      end
      db_in_valid = 0;
      for (int t = 0; t < 20 && qb.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("b_drain", qb.size(), 0);
      chk("b_count", nb_out, 1000);

      // dut_c: W=16, alternating modes, random back-pressure
      sent = 0;
      guard = 0;
      mode = 0;
      while (sent < 300 && guard < 5000) begin
         dc_in_valid  = ($urandom % 4) != 0;
         dc_in_a      = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
         dc_in_b      = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
         dc_in_approx = mode;
         dc_out_ready = ($urandom % 10) < 7;
         @(negedge clk);
         if (dc_in_valid && dc_in_ready) begin
            sent++;
            mode = ~mode;
         end
         @(posedge clk); #1;
         guard++;
      end
      dc_in_valid  = 0;
      dc_out_ready = 1;
      for (int t = 0; t < 20 && qc.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("c_drain", qc.size(), 0);
      chk("c_count", nc_out, 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
